// File: rtl/sat_accum_seq_if.sv
// Handshake/bus bundle for the saturating burst accumulator.
// The master side issues bursts and operands; the slave side is the accumulator.
interface sat_accum_seq_if #(
    parameter int LEN_W  = 4,
    parameter int DATA_W = 16
);
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] result;
    logic              sat_flag;

    modport master (
        output start, len, in_valid, in_data,
        input  in_ready, busy, done, result, sat_flag
    );

    modport slave (
        input  start, len, in_valid, in_data,
        output in_ready, busy, done, result, sat_flag
    );
endinterface

// File: rtl/sat_accum_seq.sv
// Signed saturating burst accumulator: sums len two's-complement operands from a
// valid/ready stream into one clamped result, one accepted beat per cycle.
module sat_accum_seq #(
    parameter int LEN_W  = 4,
    parameter int DATA_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    sat_accum_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] acc;
    logic [LEN_W-1:0]  remaining;
    logic              sat;
    logic              in_ready;
    logic              beat;
    logic [DATA_W-1:0] sum_raw;
    logic [DATA_W-1:0] sum_sat;
    logic              pos_ovf;
    logic              neg_ovf;

    // NOTE: registers use non-blocking assignments so each one samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every always_comb output is defaulted first; an uncovered branch would infer a latch.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = (bus.len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (bus.in_valid && remaining == LEN_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign beat = in_ready & bus.in_valid;

    // Same clamp rule as the downstream adder with saturation on and carry-in 0.
    assign sum_raw = acc + bus.in_data;
    assign pos_ovf = ~acc[DATA_W-1] & ~bus.in_data[DATA_W-1] &  sum_raw[DATA_W-1];
    assign neg_ovf =  acc[DATA_W-1] &  bus.in_data[DATA_W-1] & ~sum_raw[DATA_W-1];
    assign sum_sat = pos_ovf ? {1'b0, {(DATA_W-1){1'b1}}} :
                     neg_ovf ? {1'b1, {(DATA_W-1){1'b0}}} :
                               sum_raw;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            remaining <= '0;
            sat       <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            acc       <= '0;
            remaining <= bus.len;
            sat       <= 1'b0;
        end else if (beat) begin
            acc       <= sum_sat;
            remaining <= remaining - LEN_W'(1);
            if (pos_ovf || neg_ovf) begin
                sat <= 1'b1;
            end
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.busy     = (state != IDLE);
    assign bus.done     = (state == DONE);
    assign bus.result   = acc;
    assign bus.sat_flag = sat;
endmodule

// File: tb/tb_sat_accum_seq.sv
// Directed bench for sat_accum_seq: a table of whole bursts with hand-computed
// sums, plus hand-written handshake-gap, ignored-start, idle-valid and reset sequences.
module tb_sat_accum_seq;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    sat_accum_seq_if #(.LEN_W(4), .DATA_W(16)) bus ();

    sat_accum_seq #(.LEN_W(4), .DATA_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [3:0]       len;
        logic [3:0][15:0] beats;  // first four operands, beats[0] first
        logic [15:0]      fill;   // operand used for beats beyond the fourth
        logic [15:0]      res;
        logic             sat;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] len, input logic [15:0] b0, input logic [15:0] b1,
                                input logic [15:0] b2, input logic [15:0] b3, input logic [15:0] fill,
                                input logic [15:0] res, input logic sat);
        vec_t v;
        v.len      = len;
        v.beats[0] = b0;
        v.beats[1] = b1;
        v.beats[2] = b2;
        v.beats[3] = b3;
        v.fill     = fill;
        v.res      = res;
        v.sat      = sat;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start a burst, stream its operands back-to-back, and check done timing and result.
    task automatic run_burst(input string nm, input vec_t v);
        bus.start = 1'b1;
        bus.len   = v.len;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < int'(v.len); i++) begin
            check({nm, ".in_ready"}, 32'(bus.in_ready), 32'd1);
            check({nm, ".done_early"}, 32'(bus.done), 32'd0);
            bus.in_valid = 1'b1;
            if (i < 4) bus.in_data = v.beats[i];
            else       bus.in_data = v.fill;
            step();
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 16'h0000;
        check({nm, ".done"}, 32'(bus.done), 32'd1);
        check({nm, ".busy_done"}, 32'(bus.busy), 32'd1);
        check({nm, ".in_ready_done"}, 32'(bus.in_ready), 32'd0);
        check({nm, ".result"}, 32'(bus.result), 32'(v.res));
        check({nm, ".sat_flag"}, 32'(bus.sat_flag), 32'(v.sat));
        step();
        check({nm, ".done_pulse"}, 32'(bus.done), 32'd0);
        check({nm, ".busy_idle"}, 32'(bus.busy), 32'd0);
        check({nm, ".result_hold"}, 32'(bus.result), 32'(v.res));
        check({nm, ".sat_hold"}, 32'(bus.sat_flag), 32'(v.sat));
    endtask

    initial begin
        vec_t       vecs[9];
        logic [3:0] pat;

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.len      = 4'd0;
        bus.in_valid = 1'b0;
        bus.in_data  = 16'h0000;
        repeat (2) step();
        check("rst.in_ready", 32'(bus.in_ready), 32'd0);
        check("rst.busy", 32'(bus.busy), 32'd0);
        check("rst.done", 32'(bus.done), 32'd0);
        check("rst.result", 32'(bus.result), 32'd0);
        check("rst.sat_flag", 32'(bus.sat_flag), 32'd0);
        rst = 1'b0;
        step();

        vecs[0] = mk(4'd3,  16'h7228, 16'h0023, 16'h0001, 16'h0000, 16'h0000, 16'h724C, 1'b0);
        vecs[1] = mk(4'd2,  16'h7FFF, 16'h000A, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 1'b1);
        vecs[2] = mk(4'd3,  16'h7FFF, 16'h000A, 16'hFFFF, 16'h0000, 16'h0000, 16'h7FFE, 1'b1);
        vecs[3] = mk(4'd2,  16'h8000, 16'hF000, 16'h0000, 16'h0000, 16'h0000, 16'h8000, 1'b1);
        vecs[4] = mk(4'd1,  16'h0005, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0005, 1'b0);
        vecs[5] = mk(4'd0,  16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        vecs[6] = mk(4'd4,  16'h4000, 16'h4000, 16'hC000, 16'hC000, 16'h0000, 16'hFFFF, 1'b1);
        vecs[7] = mk(4'd4,  16'h8000, 16'hFFFF, 16'h0001, 16'h7FFF, 16'h0000, 16'h0000, 1'b1);
        vecs[8] = mk(4'd15, 16'h0800, 16'h0800, 16'h0800, 16'h0800, 16'h0800, 16'h7800, 1'b0);
        for (int k = 0; k < 9; k++) begin
            run_burst($sformatf("vec%0d", k), vecs[k]);
        end

        // Handshake gaps: valid pattern 1,0,0,1 with junk data on the idle cycles.
        pat       = 4'b1001;
        bus.start = 1'b1;
        bus.len   = 4'd2;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("gap.in_ready%0d", i), 32'(bus.in_ready), 32'd1);
            check($sformatf("gap.done_early%0d", i), 32'(bus.done), 32'd0);
            bus.in_valid = pat[i];
            bus.in_data  = pat[i] ? 16'h0010 : 16'h1234;
            step();
        end
        bus.in_valid = 1'b0;
        check("gap.done", 32'(bus.done), 32'd1);
        check("gap.result", 32'(bus.result), 32'h0020);
        check("gap.sat_flag", 32'(bus.sat_flag), 32'd0);
        step();
        check("gap.done_pulse", 32'(bus.done), 32'd0);

        // start pulsed mid-burst must neither reload the count nor clear the sum.
        bus.start = 1'b1;
        bus.len   = 4'd3;
        step();
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0001;
        step();
        bus.in_valid = 1'b0;
        bus.start    = 1'b1;
        bus.len      = 4'd1;
        step();
        bus.start = 1'b0;
        check("midstart.busy", 32'(bus.busy), 32'd1);
        check("midstart.in_ready", 32'(bus.in_ready), 32'd1);
        check("midstart.result", 32'(bus.result), 32'h0001);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0002;
        step();
        check("midstart.done_early", 32'(bus.done), 32'd0);
        bus.in_data = 16'h0003;
        step();
        bus.in_valid = 1'b0;
        check("midstart.done", 32'(bus.done), 32'd1);
        check("midstart.result_final", 32'(bus.result), 32'h0006);
        step();

        // in_valid while idle consumes nothing.
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h7000;
        step();
        step();
        check("idlevalid.in_ready", 32'(bus.in_ready), 32'd0);
        check("idlevalid.busy", 32'(bus.busy), 32'd0);
        check("idlevalid.result", 32'(bus.result), 32'h0006);
        run_burst("idlevalid.burst", mk(4'd1, 16'h0003, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0003, 1'b0));

        // Reset in the middle of a saturated burst discards everything.
        bus.start = 1'b1;
        bus.len   = 4'd4;
        step();
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h7FFF;
        step();
        step();
        check("midrst.pre_result", 32'(bus.result), 32'h7FFF);
        check("midrst.pre_sat", 32'(bus.sat_flag), 32'd1);
        rst          = 1'b1;
        bus.in_data  = 16'h0001;
        step();
        check("midrst.in_ready", 32'(bus.in_ready), 32'd0);
        check("midrst.busy", 32'(bus.busy), 32'd0);
        check("midrst.done", 32'(bus.done), 32'd0);
        check("midrst.result", 32'(bus.result), 32'h0000);
        check("midrst.sat_flag", 32'(bus.sat_flag), 32'd0);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        step();
        check("midrst.no_done", 32'(bus.done), 32'd0);
        check("midrst.still_idle", 32'(bus.busy), 32'd0);
        run_burst("midrst.fresh", mk(4'd2, 16'h0001, 16'h0002, 16'h0, 16'h0, 16'h0, 16'h0003, 1'b0));

        // rst wins over a simultaneous start.
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.len   = 4'd2;
        step();
        check("rststart.busy", 32'(bus.busy), 32'd0);
        check("rststart.result", 32'(bus.result), 32'h0000);
        rst       = 1'b0;
        bus.start = 1'b0;
        step();
        check("rststart.still_idle", 32'(bus.busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sat_accum_seq.md
Name: sat_accum_seq

Overview:
- Multi-cycle signed saturating accumulator for the execute stage. It sits directly upstream of the 16-bit saturating carry-lookahead adder.
- Each cycle it feeds the adder the running accumulator and the next operand, then registers the saturated sum.
- It sums a burst of N 16-bit two's-complement operands, delivered over a valid/ready handshake, into one saturated 16-bit result.

Parameters:
- LEN_W, 4, width of the burst-length field; maximum burst length is 2^LEN_W-1 (15).
- DATA_W, 16, operand and result width; fixed at 16 to match the adder.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  begin a new burst; sampled only in IDLE.
- len  input  LEN_W  number of operands in the burst; sampled with start.
- in_valid  input  1  operand on in_data is valid.
- in_data  input  16  signed operand.
- in_ready  output  1  block accepts an operand this cycle.
- busy  output  1  high in ACCUM or DONE.
- done  output  1  one-cycle pulse: result is final.
- result  output  16  accumulator value; holds after done until the next accepted start.
- sat_flag  output  1  sticky: at least one addition in this burst saturated.

Behaviour:
- Interface: one clock; reset is synchronous and active-high; clock port clk, reset port rst.
- Reset: state=IDLE, in_ready=0, busy=0, done=0, result=16'h0000, sat_flag=0, remaining count=0.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - start=1 with len!=0 -> ACCUM. On that edge: accumulator cleared to 0, sat_flag cleared, remaining count loaded with len.
  - start=1 with len=0 -> DONE directly, with result=0 and sat_flag=0.
- ACCUM:
  - in_ready=1. A beat is accepted when in_valid&in_ready at the rising edge.
  - Per accepted beat: acc <= sat(acc + in_data) and remaining decrements.
  - Beat accepted with remaining==1 -> DONE.
  - No beat accepted -> stay; acc unchanged.
- DONE: done=1 and in_ready=0 for exactly one cycle, then unconditional -> IDLE.
- Saturating add, identical to the adder with saturation enabled and carry-in 0:
  - Raw 16-bit sum S = acc + in_data.
  - Both operands non-negative and S[15]=1 -> 16'h7FFF.
  - Both operands negative and S[15]=0 -> 16'h8000.
  - Otherwise S.
- Saturation is not sticky in value: later beats keep adding to the clamped value. Example: 7FFF then +(-1) gives 7FFE.
- sat_flag is set on any clamping beat and held until the next accepted start.
- result reflects acc at all times. It is final once done pulses, then held through IDLE.
- start is ignored while busy; len is not re-sampled.
- in_valid outside ACCUM is ignored; no beat is consumed.
- Latency:
  - start accepted at edge t -> in_ready high from cycle t+1.
  - Minimum burst of N beats with in_valid held high: done at cycle t+N+1.
  - len=0: done at cycle t+1.
- Reset asserted in any state, including mid-burst, returns everything to reset values on that edge. Partial sums are discarded.
- start and rst together: rst wins.

Test Plan:
- Basic sum: start, len=3, beats 0x7228, 0x0023, 0x0001 with in_valid held -> done pulses 4 cycles after start; result=0x724C, sat_flag=0.
- Positive clamp: len=2, beats 0x7FFF, 0x000A -> result=0x7FFF, sat_flag=1. Recovery: len=3, beats 0x7FFF, 0x000A, 0xFFFF -> result=0x7FFE, sat_flag=1.
- Negative clamp: len=2, beats 0x8000, 0xF000 -> result=0x8000, sat_flag=1. Next burst len=1, beat 0x0005 -> result=0x0005, sat_flag=0.
- Handshake gaps: len=2, in_valid toggled 1,0,0,1 with data 0x0010 on the valid cycles -> exactly 2 beats accepted; result=0x0020; in_ready=1 through every gap; done one cycle after the 2nd accepted beat.
- Edge cases:
  - len=0 -> done the cycle after start, result=0.
  - start pulsed during ACCUM -> ignored; count unchanged.
  - in_valid high in IDLE -> no beat consumed.
- Mid-burst reset: len=4, rst asserted after 2 beats -> next cycle state IDLE, in_ready=0, result=0, sat_flag=0, no done. A fresh burst then runs normally.
